// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Round-robin, non-preemptive arbiter sharing the unified memory port among
// four requesters (fetch, load/store, DMA, debug). A grant is issued from IDLE,
// held through ISSUE/WAIT and released on ack. Every output is registered, so
// the downstream 4:1 mux select never carries X.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that forces a
// release (with a one-cycle timeout_err pulse) when a grant stays outstanding
// for TIMEOUT_CYCLES cycles without ack.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   req          in   4  level-sensitive request, bit i = requester i
//   ack          in   1  completion pulse from the shared resource
//   grant        out  4  one-hot grant, zero when idle
//   sel          out  2  index of the current or most recent grantee
//   start        out  1  strobe on the first cycle of a transaction
//   busy         out  1  high while a grant is outstanding
//   timeout_err  out  1  pulse on forced release (0 without the macro)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       start,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0] state_r;
    logic [1:0] ptr_r;
    logic [3:0] grant_r;
    logic [1:0] sel_r;
    logic       start_r;
    logic       busy_r;
    logic       timeout_err_r;

    logic [1:0] win_s;
    logic [1:0] cand_s;
    logic       found_s;
    logic       timeout_hit_s;

    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4), first request wins.
    always_comb begin
        win_s   = ptr_r;
        cand_s  = ptr_r;
        found_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand_s = ptr_r + 2'(i);
            if (!found_s && req[cand_s]) begin
                win_s   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;

    // Watchdog fires when the outstanding grant has already aged TIMEOUT_CYCLES.
    always_comb begin
        if (state_r != IDLE) begin
            timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Age counter: held at zero in IDLE so it starts cleared on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == IDLE) begin
            cnt_r <= '0;
        end else if (!ack && !timeout_hit_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    // Without the watchdog a grant is only ever released by ack.
    always_comb begin
        timeout_hit_s    = 1'b0;
        unused_timeout_s = (TIMEOUT_CYCLES == 0);
    end
`endif

    // Main FSM and registered outputs; sel only moves when a new grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ptr_r         <= 2'd0;
            grant_r       <= 4'b0000;
            sel_r         <= 2'd0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_err_r <= 1'b0;
                    if (found_s) begin
                        state_r <= ISSUE;
                        grant_r <= 4'b0001 << win_s;
                        sel_r   <= win_s;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        grant_r <= 4'b0000;
                        start_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ISSUE, WAIT: begin
                    start_r <= 1'b0;
                    if (ack || timeout_hit_s) begin
                        // ack has priority: a simultaneous timeout is not an error.
                        state_r       <= IDLE;
                        grant_r       <= 4'b0000;
                        busy_r        <= 1'b0;
                        ptr_r         <= sel_r + 2'd1;
                        timeout_err_r <= !ack;
                    end else begin
                        state_r       <= WAIT;
                        timeout_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    grant_r       <= 4'b0000;
                    start_r       <= 1'b0;
                    busy_r        <= 1'b0;
                    timeout_err_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign sel         = sel_r;
    assign start       = start_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: directed scenarios with constant
// expectations plus a randomized run compared against a transaction-level
// reference model (owner/pointer bookkeeping, no state encoding).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       start;
    logic       busy;
    logic       timeout_err;

    int vectors;
    int miscompares;

    // reference model state
    int         m_ptr;
    int         m_owner;
    int         m_cnt;
    bit         m_busy;
    bit         m_start;
    bit         m_err;
    logic [1:0] m_sel;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .sel         (sel),
        .start       (start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] observed();
        return {grant, sel, start, busy, timeout_err};
    endfunction

    function automatic logic [8:0] model_out();
        logic [3:0] g;
        g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        return {g, m_sel, m_start, m_busy, m_err};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0;
        m_busy = 1'b0; m_start = 1'b0; m_err = 1'b0; m_sel = 2'd0;
    endtask

    // One clock edge of the transaction-level behaviour.
    task automatic model_step(input logic [3:0] r, input logic a);
        bit found;
        m_start = 1'b0;
        m_err   = 1'b0;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_start = 1'b1;
                m_sel   = 2'(m_owner);
                m_cnt   = 0;
            end
        end else if (a) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 4;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            if (m_cnt == TO) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
                m_err  = 1'b1;
            end else begin
                m_cnt++;
            end
`else
            m_cnt++;
`endif
        end
    endtask

    // Apply inputs for one cycle; returns at the following negedge.
    task automatic drive(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        model_step(r, a);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        model_reset();
        #3;
        vectors++;
        if (observed() !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_values got=%b want=%b", observed(), 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(4'b0000, c[0]);
            vectors++;
            if (observed() !== 9'd0) begin
                miscompares++;
                $display("FAIL idle_no_req cyc=%0d got=%b want=%b", c, observed(), 9'd0);
            end
        end
    endtask

    task automatic test_single();
        logic [8:0] exp [4];
        exp[0] = {4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
        exp[1] = {4'b0100, 2'd2, 1'b0, 1'b1, 1'b0};
        exp[2] = {4'b0100, 2'd2, 1'b0, 1'b1, 1'b0};
        exp[3] = {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            drive((c == 0) ? 4'b0100 : 4'b0000, (c == 3));
            vectors++;
            if (observed() !== exp[c]) begin
                miscompares++;
                $display("FAIL single_req cyc=%0d got=%b want=%b", c + 2, observed(), exp[c]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            w = 2'(k % 4);
            drive(4'b1111, 1'b0);
            vectors++;
            if (observed() !== {4'b0001 << w, w, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL rotation_issue k=%0d got=%b want=%b", k, observed(),
                         {4'b0001 << w, w, 1'b1, 1'b1, 1'b0});
            end
            drive(4'b1111, 1'b0);
            vectors++;
            if (observed() !== {4'b0001 << w, w, 1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL rotation_wait k=%0d got=%b want=%b", k, observed(),
                         {4'b0001 << w, w, 1'b0, 1'b1, 1'b0});
            end
            drive(4'b1111, 1'b1);
            vectors++;
            if (observed() !== {4'b0000, w, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL rotation_idle k=%0d got=%b want=%b", k, observed(),
                         {4'b0000, w, 1'b0, 1'b0, 1'b0});
            end
        end
    endtask

    // After the rotation run ptr points at 1, so req[1] alone wins at once.
    task automatic test_drop_req();
        for (int c = 1; c <= 6; c++) begin
            drive((c <= 2) ? 4'b0010 : 4'b0000, 1'b0);
            vectors++;
            if (grant !== 4'b0010 || sel !== 2'd1) begin
                miscompares++;
                $display("FAIL drop_req_hold cyc=%0d got=%b/%0d want=0010/1", c, grant, sel);
            end
        end
        drive(4'b0000, 1'b1);
        vectors++;
        if (observed() !== {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_req_release got=%b want=%b", observed(),
                     {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0});
        end
    endtask

    // ptr is now 2; requester 3 alone wins, then reset lands mid-WAIT.
    task automatic test_async_reset();
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
        vectors++;
        if (grant !== 4'b1000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_grant got=%b want=1000", grant);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (observed() !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%b want=%b", observed(), 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 1'b0);
        vectors++;
        if (observed() !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset_prio got=%b want=%b", observed(),
                     {4'b0001, 2'd0, 1'b1, 1'b1, 1'b0});
        end
        drive(4'b0000, 1'b1);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        drive(4'b0001, 1'b0);
        for (int c = 0; c < TO; c++) begin
            drive(4'b0000, 1'b0);
            vectors++;
            if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_hold cyc=%0d got=%b/%b want=0001/0", c, grant, timeout_err);
            end
        end
        drive(4'b0000, 1'b0);
        vectors++;
        if (observed() !== {4'b0000, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_pulse got=%b want=%b", observed(),
                     {4'b0000, 2'd0, 1'b0, 1'b0, 1'b1});
        end
        drive(4'b0011, 1'b0);
        vectors++;
        if (observed() !== {4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_next got=%b want=%b", observed(),
                     {4'b0010, 2'd1, 1'b1, 1'b1, 1'b0});
        end
        drive(4'b0000, 1'b1);
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        logic       a;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            a = ($urandom_range(0, 2) == 0);
            drive(r, a);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("FAIL random cyc=%0d req=%b ack=%b got=%b want=%b",
                         c, r, a, observed(), model_out());
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_rotation();
        test_drop_req();
        test_async_reset();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port resource (the pipeline's unified memory port) among four requesters. Fetch, load/store, DMA and debug each request the port. The block grants one requester at a time, drives the 2-bit select of the 4:1 mux that routes that requester's address/data onto the port, and holds the grant until the resource acknowledges completion. The select output is always a registered, known value, so the downstream mux never sees X on its select during stalls.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a grant may stay outstanding without `ack` before forced release. Legal range ≥1. Used only when the macro in Configuration is defined.

- `clk`  in  1  — single clock; rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req`  in  4  — request per requester. Bit i is requester i. Level-sensitive.
- `ack`  in  1  — completion pulse from the shared resource for the current transaction.
- `grant`  out  4  — one-hot grant; all zero when idle.
- `sel`  out  2  — mux select, equal to the index of the current or most recent grantee.
- `start`  out  1  — one-cycle strobe to the resource marking the first cycle of a transaction.
- `busy`  out  1  — high while a grant is outstanding.
- `timeout_err`  out  1  — one-cycle pulse on forced release.

## Operation
- **FSM states:**
  - IDLE: no grant.
  - ISSUE: first grant cycle; `start`=1.
  - WAIT: grant held.
- **Transitions:**
  - IDLE → ISSUE when `req` != 0.
  - ISSUE → IDLE if `ack`=1, else ISSUE → WAIT.
  - WAIT → IDLE on `ack`.
  - WAIT → IDLE on timeout (macro only).
- **Arbitration:**
  - Happens only in IDLE.
  - Priority starts at `ptr` and descends `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4.
  - The winner w is registered into `grant`/`sel`.
  - On release, `ptr` ← (w+1) mod 4.
- **Outputs in IDLE:** `grant`=0 and `busy`=0; `sel` holds the last winner.
- **Grant is non-preemptive.**
  - Deasserting `req[w]` mid-transaction has no effect; the grant holds until `ack`/timeout.
  - Requests arriving during a grant are not latched; they are re-sampled in the next IDLE.
- **`ack`:**
  - Ignored in IDLE.
  - Honoured in ISSUE and WAIT.
- **Reset values:** state=IDLE, `ptr`=0, `grant`=0, `sel`=0, `start`=0, `busy`=0, `timeout_err`=0.
- **Reset mid-transaction:** the grant is dropped immediately (asynchronous) and no `timeout_err` is produced.

## Timing
- **Request to grant:**
  - `req` is sampled in IDLE at edge T.
  - `grant`/`sel`/`start`/`busy` are valid after T (cycle T+1). All outputs are registered.
- **`start`:** high exactly one cycle per transaction (the ISSUE cycle).
- **Grant release:**
  - `ack` sampled high at edge E releases the grant; `grant`=0 and `busy`=0 from E+1.
  - Minimum grant length is 1 cycle (ack in ISSUE).
- **Back-to-back:** one IDLE cycle between consecutive grants. Arbitration occurs in that cycle, so the turnaround is 2 edges from ack to the next `start`.
- **`sel` stability:** `sel` changes only on the edge that asserts a new grant and is stable for the entire grant.
- **Fairness:** with all four requests held high, grants rotate 0,1,2,3,0…; each requester waits at most 3 transactions.

## Configuration
- **Macro:** `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - Counter width is ceil(log2(`TIMEOUT_CYCLES`+1)).
  - The counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT without `ack`.
  - When the count reaches `TIMEOUT_CYCLES`, the block returns to IDLE on the next edge, pulses `timeout_err` for 1 cycle coincident with `grant` clearing, and advances `ptr` as for a normal release.
  - If `ack` and timeout occur on the same edge, `ack` wins and there is no error.
- **Undefined:** no counter; WAIT is left only on `ack`; `timeout_err` is tied 0.

## Test plan
- Reset, then `req`=4'b0000 for 10 cycles → `grant`=0, `sel`=0, `busy`=0, `start` never high.
- `req`=4'b0100 at cycle 1, `ack` at cycle 4 → `grant`=4'b0100 and `sel`=2 in cycles 2–4; `start` only in cycle 2; `grant`=0 in cycle 5 with `sel` still 2.
- `req`=4'b1111 held, `ack` on the second cycle of each grant → grant order 0,1,2,3,0, each `start` separated by 3 cycles, `sel` matching the grant.
- `req[1]` dropped in cycle 3 of its grant with `ack` arriving at cycle 6 → `grant`=4'b0010 held through cycle 6.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `req`=4'b0001 and no `ack` → `timeout_err` pulses once as `grant` clears. The next `req`=4'b0011 grants requester 1 first.
- `rst_n` asserted low mid-WAIT with `grant`=4'b1000 → all outputs reach reset values before the next edge; after release, requester 0 has priority.
